// File: rtl/dff_share_arb.sv
// -----------------------------------------------------------------------------
// dff_share_arb
//
// Round-robin arbiter guarding one shared WIDTH-bit register. Each cycle at
// most one requester wins; its data is loaded into the shared register on the
// same edge that raises its grant. The block also tracks which requester last
// wrote the register, whether the register holds requester data, and a
// saturating count of accepted writes.
//
// Optional feature macro: DFF_SHARE_ARB_LOCK_EN
//   When defined, a per-requester lock input lets the winner keep exclusive
//   access (LOCKED state) until it drops its lock bit.
//
// Parameters
//   N_REQ   number of requesters (2..16)
//   WIDTH   shared register width (>= 1)
//   OW      owner index width, derived from N_REQ
//
// Ports
//   clk       in   clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [N_REQ]        level write request per requester
//   wdata     in   [N_REQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   clr       in   synchronous clear of the shared register, beats requests
//   lock      in   [N_REQ]        lock request (only with DFF_SHARE_ARB_LOCK_EN)
//   gnt       out  [N_REQ]        registered one-hot grant pulse
//   q         out  [WIDTH]        shared register
//   q_owner   out  [OW]           index of the requester that last wrote q
//   q_vld     out  q holds requester data since reset / clr
//   wr_count  out  [16]           accepted writes since reset, saturating
// -----------------------------------------------------------------------------
module dff_share_arb #(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int OW    = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   input  logic                   clr,
`ifdef DFF_SHARE_ARB_LOCK_EN
   input  logic [N_REQ-1:0]       lock,
`endif
   output logic [N_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]       q,
   output logic [OW-1:0]          q_owner,
   output logic                   q_vld,
   output logic [15:0]            wr_count
);

   // --------------------------------------------------------------------------
   // State encoding. IDLE and GRANT mirror gnt == 0 / gnt one-hot; LOCKED only
   // exists when the lock feature is built in.
   // --------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GRANT  = 2'd1;
`ifdef DFF_SHARE_ARB_LOCK_EN
   localparam logic [1:0] S_LOCKED = 2'd2;
`endif

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
   // N_REQ expressed in the OW+1 bit width used for modulo arithmetic.
   localparam logic [OW:0]      N_REQ_W  = (OW+1)'(N_REQ);
   localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   logic [N_REQ-1:0] r_gnt;
   logic [WIDTH-1:0] r_q;
   logic [OW-1:0]    r_owner;
   logic             r_vld;
   logic [15:0]      r_cnt;
   logic [OW-1:0]    r_ptr;
   logic [1:0]       r_state;

   // --------------------------------------------------------------------------
   // Combinational arbitration
   // --------------------------------------------------------------------------
   logic             w_lock_hold;   // LOCKED and the owner still holds its lock
   logic             w_lock_win;    // winner asks for a lock on this edge
   logic [N_REQ-1:0] w_elig;
   logic             w_found;
   logic [OW-1:0]    w_win;
   logic [OW:0]      w_sum;
   logic [OW:0]      w_next;
   logic [1:0]       w_state_nxt;

`ifdef DFF_SHARE_ARB_LOCK_EN
   assign w_lock_hold = (r_state == S_LOCKED) && lock[r_owner];
   assign w_lock_win  = lock[w_win];
`else
   assign w_lock_hold = 1'b0;
   assign w_lock_win  = 1'b0;
`endif

   // Eligible set. The requester granted last cycle is masked so nobody wins
   // two edges in a row; a level req still high afterwards is a new request.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_elig = req & ~r_gnt;
      case (r_state)
         S_IDLE:  w_elig = req;            // gnt is zero, nothing to mask
         S_GRANT: w_elig = req & ~r_gnt;
`ifdef DFF_SHARE_ARB_LOCK_EN
         S_LOCKED: begin
            // While the lock is held only the owner may compete.
            if (w_lock_hold) begin
               w_elig = req & ~r_gnt & (ONE_HOT0 << r_owner);
            end else begin
               w_elig = req & ~r_gnt;
            end
         end
`endif
         default: w_elig = req & ~r_gnt;
      endcase
   end

   // Search upward from the pointer, wrapping modulo N_REQ; first hit wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (OW+1)'(i);
         if (w_sum >= N_REQ_W) begin
            w_sum = w_sum - N_REQ_W;
         end
         if (!w_found && w_elig[w_sum[OW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[OW-1:0];
         end
      end
   end

   // Pointer moves to the slot just after the winner.
   always_comb begin
      w_next = {1'b0, w_win} + (OW+1)'(1);
      if (w_next == N_REQ_W) begin
         w_next = '0;
      end
   end

   // Next state for the non-clear cases; clr is handled in the register block.
   always_comb begin
      w_state_nxt = S_IDLE;
      if (w_found) begin
         w_state_nxt = S_GRANT;
`ifdef DFF_SHARE_ARB_LOCK_EN
         if (w_lock_hold || w_lock_win) begin
            w_state_nxt = S_LOCKED;
         end
`endif
      end else begin
`ifdef DFF_SHARE_ARB_LOCK_EN
         // Owner is gnt-masked this edge but keeps its lock.
         if (w_lock_hold) begin
            w_state_nxt = S_LOCKED;
         end
`endif
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_gnt   <= '0;
         r_q     <= '0;
         r_owner <= '0;
         r_vld   <= 1'b0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_state <= S_IDLE;
      end else if (clr) begin
         // Clear wins over any request; ptr and the write count are kept, and
         // pending requests simply re-arbitrate next cycle.
         r_gnt   <= '0;
         r_q     <= '0;
         r_owner <= '0;
         r_vld   <= 1'b0;
         r_state <= S_IDLE;
      end else if (w_found) begin
         r_gnt   <= ONE_HOT0 << w_win;
         r_q     <= wdata[w_win*WIDTH +: WIDTH];
         r_owner <= w_win;
         r_vld   <= 1'b1;
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 16'd1;
         end
         // A locked owner re-winning does not move the round-robin pointer.
         if (!w_lock_hold) begin
            r_ptr <= w_next[OW-1:0];
         end
         r_state <= w_state_nxt;
      end else begin
         r_gnt   <= '0;
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs are driven straight from flops.
   // --------------------------------------------------------------------------
   assign gnt      = r_gnt;
   assign q        = r_q;
   assign q_owner  = r_owner;
   assign q_vld    = r_vld;
   assign wr_count = r_cnt;

endmodule
